hpc3_rand_source: RTL and testbench

- Upstream randomness stage for the HPC3 multiplier pairs in the masked AES datapath.
- Expands a 64-bit seed with a registered Fibonacci LFSR, unrolled for several steps per cycle.
- Supplies fresh in_r and in_p vectors to NUM_MULS hpc3_mul instances every enabled cycle.
- Gives each multiplier its own r (no sharing of r between multipliers).
- Handles seeding, warm-up and a valid/enable protocol, so consumers never see stale or repeated masks.

---
 rtl/hpc3_rand_source.sv | 79 +++++++
 tb/tb_hpc3_rand_source.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hpc3_rand_source.sv
// hpc3_rand_source: unrolled 64-bit Fibonacci LFSR that feeds fresh r/p masks to HPC3 multipliers
module hpc3_rand_source #(
    parameter int NUM_SHARES    = 3,
    parameter int BIT_WIDTH     = 1,
    parameter int NUM_MULS      = 2,
    parameter int WARMUP_CYCLES = 8,
    localparam int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2,
    localparam int R_BITS        = NUM_MULS * NUM_QUADRATIC * BIT_WIDTH,
    localparam int STEP_BITS     = 2 * R_BITS
) (
    input  logic              in_clock,
    input  logic              in_reset,
    input  logic [63:0]       in_seed,
    input  logic              in_seed_valid,
    output logic              out_seed_ready,
    input  logic              in_enable,
    output logic              out_valid,
    output logic [R_BITS-1:0] out_r,
    output logic [R_BITS-1:0] out_p
);
    typedef enum logic [1:0] {UNSEEDED, WARMUP, RUN} state_t;
    state_t                r_state, w_next;
    logic [63:0]           r_lfsr, w_adv;
    logic [STEP_BITS-1:0]  w_stream;
    logic [7:0]            r_cnt;
    logic [R_BITS-1:0]     r_out_r, r_out_p;
    logic                  w_seed_hs, w_last_warm, w_load, w_adv_en;
    if (STEP_BITS > 64) begin : g_step_chk
        $error("hpc3_rand_source: STEP_BITS exceeds 64");
    end
    if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255) begin : g_warm_chk
        $error("hpc3_rand_source: WARMUP_CYCLES out of range 1..255");
    end
    always_comb begin
        w_adv    = r_lfsr;
        w_stream = '0;
        for (int k = 0; k < STEP_BITS; k++) begin
            w_stream[k] = w_adv[63] ^ w_adv[62] ^ w_adv[60] ^ w_adv[59];
            w_adv       = {w_adv[62:0], w_stream[k]};
        end
    end
    // Counter starts at WARMUP_CYCLES so that many discard advances precede the first load.
    assign w_seed_hs   = in_seed_valid && out_seed_ready;
    assign w_last_warm = (r_state == WARMUP) && (r_cnt == 8'd0);
    assign w_load      = !w_seed_hs && (w_last_warm || ((r_state == RUN) && in_enable));
    assign w_adv_en    = (r_state == WARMUP) || w_load;
    always_ff @(posedge in_clock) begin
        r_state <= in_reset ? UNSEEDED : w_next;
    end
    always_comb begin
        w_next = w_seed_hs ? WARMUP : w_last_warm ? RUN : r_state;
    end
    always_comb begin
        out_seed_ready = (r_state != WARMUP);
        out_valid      = (r_state == RUN);
    end
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_lfsr  <= '0;
            r_cnt   <= '0;
            r_out_r <= '0;
            r_out_p <= '0;
        end else if (w_seed_hs) begin
            r_lfsr <= (in_seed == '0) ? 64'h1 : in_seed;
            r_cnt  <= 8'(WARMUP_CYCLES);
        end else begin
            if (w_adv_en)
                r_lfsr <= w_adv;
            if ((r_state == WARMUP) && (r_cnt != 8'd0))
                r_cnt <= r_cnt - 8'd1;
            if (w_load) begin
                r_out_r <= w_stream[R_BITS-1:0];
                r_out_p <= w_stream[STEP_BITS-1:R_BITS];
            end
        end
    end
    assign out_r = r_out_r;
    assign out_p = r_out_p;
endmodule

// File: tb/tb_hpc3_rand_source.sv
// tb_hpc3_rand_source: random/directed checks of hpc3_rand_source against a bit-queue LFSR recurrence model
module tb_hpc3_rand_source;
    localparam int NS = 3;
    localparam int BW = 1;
    localparam int NM = 2;
    localparam int W  = 8;
    localparam int NQ = NS * (NS - 1) / 2;
    localparam int R  = NM * NQ * BW;
    localparam int S  = 2 * R;

    logic          in_clock = 1'b0;
    logic          in_reset;
    logic [63:0]   in_seed;
    logic          in_seed_valid;
    logic          out_seed_ready;
    logic          in_enable;
    logic          out_valid;
    logic [R-1:0]  out_r;
    logic [R-1:0]  out_p;

    int            tests = 0;
    int            fails = 0;
    bit            q[$];
    logic [S-1:0]  exp_c;

    always #5 in_clock = ~in_clock;

    hpc3_rand_source #(
        .NUM_SHARES(NS), .BIT_WIDTH(BW), .NUM_MULS(NM), .WARMUP_CYCLES(W)
    ) dut (
        .in_clock(in_clock),
        .in_reset(in_reset),
        .in_seed(in_seed),
        .in_seed_valid(in_seed_valid),
        .out_seed_ready(out_seed_ready),
        .in_enable(in_enable),
        .out_valid(out_valid),
        .out_r(out_r),
        .out_p(out_p)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge in_clock);
        #1;
    endtask

    // Stream bit n obeys x[n] = x[n-64]^x[n-63]^x[n-61]^x[n-60]; queue front is the oldest bit.
    task automatic m_load(input logic [63:0] s);
        logic [63:0] v;
        v = (s == 64'd0) ? 64'd1 : s;
        q.delete();
        for (int j = 0; j < 64; j++) q.push_back(v[63-j]);
    endtask

    task automatic m_adv(output logic [S-1:0] c);
        bit b;
        c = '0;
        for (int k = 0; k < S; k++) begin
            b = q[0] ^ q[1] ^ q[3] ^ q[4];
            void'(q.pop_front());
            q.push_back(b);
            c[k] = b;
        end
    endtask

    task automatic chk_out(input string tag, input logic v);
        chk({tag, " valid"}, 64'(out_valid), 64'(v));
        chk({tag, " data"}, 64'({out_p, out_r}), 64'(exp_c));
    endtask

    task automatic warm(input bit pend, input logic [63:0] ps);
        logic [S-1:0] junk;
        for (int i = 0; i < W; i++) begin
            in_enable     = 1'($urandom_range(0, 1));
            in_seed_valid = pend;
            in_seed       = ps;
            chk("warm ready", 64'(out_seed_ready), 64'd0);
            chk_out("warm stale", 1'b0);
            tick();
            m_adv(junk);
        end
        chk("warm ready end", 64'(out_seed_ready), 64'd0);
        chk_out("warm end", 1'b0);
        in_enable = 1'b1;
        tick();
        m_adv(exp_c);
        chk_out("first load", 1'b1);
        chk("run ready", 64'(out_seed_ready), 64'd1);
    endtask

    task automatic do_seed(input logic [63:0] s, input bit pend, input logic [63:0] ps);
        in_seed       = s;
        in_seed_valid = 1'b1;
        in_enable     = 1'($urandom_range(0, 1));
        chk("seed ready", 64'(out_seed_ready), 64'd1);
        tick();
        in_seed_valid = 1'b0;
        m_load(s);
        warm(pend, ps);
    endtask

    task automatic step(input bit en, input string tag);
        in_enable = en;
        tick();
        if (en) m_adv(exp_c);
        chk_out(tag, 1'b1);
    endtask

    initial begin
        logic [63:0] rs;
        in_reset      = 1'b1;
        in_seed       = '0;
        in_seed_valid = 1'b0;
        in_enable     = 1'b0;
        exp_c         = '0;
        tick();
        tick();
        in_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_enable = 1'($urandom_range(0, 1));
            tick();
            chk_out("idle", 1'b0);
            chk("idle ready", 64'(out_seed_ready), 64'd1);
        end

        do_seed(64'h0123_4567_89AB_CDEF, 1'b0, 64'd0);
        for (int i = 0; i < 100; i++) step(1'b1, "golden");

        do_seed(64'h0, 1'b0, 64'd0);
        for (int i = 0; i < 10; i++) step(1'b1, "seed0");
        do_seed(64'h1, 1'b0, 64'd0);
        for (int i = 0; i < 10; i++) step(1'b1, "seed1");

        step(1'b1, "pat en1");
        step(1'b0, "pat hold1");
        step(1'b0, "pat hold2");
        step(1'b1, "pat resume");
        for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), "rand en");

        rs = {$urandom, $urandom};
        do_seed(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, rs);
        do_seed(rs, 1'b0, 64'd0);
        for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), "pending seed");

        in_seed       = 64'hDEAD_BEEF_0000_1234;
        in_seed_valid = 1'b1;
        tick();
        in_seed_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("midwarm valid", 64'(out_valid), 64'd0);
        in_reset = 1'b1;
        tick();
        in_reset = 1'b0;
        exp_c    = '0;
        chk_out("reset midwarm", 1'b0);
        chk("reset ready", 64'(out_seed_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("post reset idle", 1'b0);
        end
        do_seed({$urandom, $urandom}, 1'b0, 64'd0);
        for (int i = 0; i < 10; i++) step(1'b1, "after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
